spi_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one SPI master byte-transfer engine between NUM_REQ independent requesters.
- Each requester presents one byte. The arbiter grants one requester at a time, pulses the engine's start, waits for done, returns the received byte with a one-cycle ack, then enforces an inter-transfer gap.
- Sits between client logic and the SPI master's start/data_in/data_out/done interface.

---
 rtl/spi_req_arbiter_if.sv | 30 +++
 rtl/spi_req_arbiter.sv | 131 +++++++++++++
 tb/tb_spi_req_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_req_arbiter_if.sv
// Bundle of the client-side request/response signals and the SPI master
// byte-engine handshake that the arbiter sits between.
interface spi_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] wdata;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           rdata;
  logic                 busy;
  logic [IDX_W-1:0]     grant_idx;
  logic                 spi_start;
  logic [7:0]           spi_data_in;
  logic [7:0]           spi_data_out;
  logic                 spi_done;

  // Arbiter view: consumes requests and engine results, drives grants/start.
  modport master (
    input  req, wdata, spi_data_out, spi_done,
    output ack, rdata, busy, grant_idx, spi_start, spi_data_in
  );

  // Environment view: clients plus SPI engine.
  modport slave (
    output req, wdata, spi_data_out, spi_done,
    input  ack, rdata, busy, grant_idx, spi_start, spi_data_in
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI byte-transfer engine between
// NUM_REQ requesters: grant, start pulse, wait for done, ack with the
// received byte, then hold off for GAP_CYCLES before the next grant.
module spi_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  spi_req_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Pointer starts at the last requester so requester 0 wins first after reset.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  state_t           state_q,   state_d;
  logic [IDX_W-1:0] last_q,    last_d;
  logic [IDX_W-1:0] grant_q,   grant_d;
  logic [7:0]       data_in_q, data_in_d;
  logic [7:0]       rdata_q,   rdata_d;
  logic [GAP_W-1:0] gap_q,     gap_d;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;

  // Round-robin scan starting just after the last grant, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int c;
      c = (int'(last_q) + i) % NUM_REQ;
      if (!pick_vld && bus.req[c]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(c);
      end
    end
  end

  // Sequencer next-state: grant, start, wait for done, respond, gap.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    data_in_d = data_in_q;
    rdata_d   = rdata_q;
    gap_d     = gap_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d   = pick_idx;
          last_d    = pick_idx;
          data_in_d = bus.wdata[8*int'(pick_idx) +: 8];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A done pulse here belongs to nothing we started; ignore it.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.spi_done) begin
          rdata_d = bus.spi_data_out;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (GAP_CYCLES > 0) begin
          gap_d   = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= LAST_RST;
      grant_q   <= '0;
      data_in_q <= '0;
      rdata_q   <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      data_in_q <= data_in_d;
      rdata_q   <= rdata_d;
      gap_q     <= gap_d;
    end
  end

  // Outputs decoded from state: one-hot ack only in RESP, start only in ISSUE.
  always_comb begin
    bus.ack = '0;
    if (state_q == S_RESP) begin
      bus.ack[grant_q] = 1'b1;
    end
    bus.busy        = (state_q != S_IDLE);
    bus.spi_start   = (state_q == S_ISSUE);
    bus.grant_idx   = grant_q;
    bus.spi_data_in = data_in_q;
    bus.rdata       = rdata_q;
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: the bench plays both the clients and
// the SPI byte engine. A second instance with a 3-cycle gap covers gap timing.
module tb_spi_req_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  spi_req_arbiter_if #(.NUM_REQ(4)) bus ();
  spi_req_arbiter_if #(.NUM_REQ(4)) bus2 ();

  spi_req_arbiter #(.NUM_REQ(4), .GAP_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  spi_req_arbiter #(.NUM_REQ(4), .GAP_CYCLES(3)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for a start on the main instance, check the grant, then
  // answer as the SPI engine and check the ack/rdata.
  task automatic xfer(input string tag, input logic [1:0] exp_idx,
                      input logic [7:0] exp_data, input logic [7:0] rx);
    int n;
    n = 0;
    while (bus.spi_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, bus.spi_start, 1);
    chk({tag, "_grant"}, bus.grant_idx, exp_idx);
    chk({tag, "_din"}, bus.spi_data_in, exp_data);
    tick();
    bus.spi_data_out = rx;
    bus.spi_done     = 1'b1;
    tick();
    bus.spi_done     = 1'b0;
    chk({tag, "_ack"}, bus.ack, 4'b0001 << exp_idx);
    chk({tag, "_rdata"}, bus.rdata, rx);
    tick();
    chk({tag, "_ack_off"}, bus.ack, 4'b0000);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.req  = '0;
    bus.wdata = '0;
    bus.spi_data_out = '0;
    bus.spi_done = 1'b0;
    bus2.req = '0;
    bus2.wdata = '0;
    bus2.spi_data_out = '0;
    bus2.spi_done = 1'b0;

    // Reset values
    tick();
    chk("rst_ack", bus.ack, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant_idx, 0);
    chk("rst_start", bus.spi_start, 0);
    chk("rst_din", bus.spi_data_in, 0);
    tick();
    rst = 1'b0;

    // Single transfer on requester 2
    bus.req = 4'b0100;
    bus.wdata[23:16] = 8'hA5;
    tick();
    chk("t1_start", bus.spi_start, 1);
    chk("t1_busy_issue", bus.busy, 1);
    chk("t1_grant", bus.grant_idx, 2);
    chk("t1_din", bus.spi_data_in, 8'hA5);
    tick();
    chk("t1_start_off", bus.spi_start, 0);
    bus.spi_data_out = 8'h3C;
    bus.spi_done = 1'b1;
    tick();
    bus.spi_done = 1'b0;
    chk("t1_ack", bus.ack, 4'b0100);
    chk("t1_rdata", bus.rdata, 8'h3C);
    bus.req = 4'b0000;
    tick();
    chk("t1_gap1_busy", bus.busy, 1);
    chk("t1_gap1_ack", bus.ack, 0);
    tick();
    chk("t1_gap2_busy", bus.busy, 1);
    tick();
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_idle_start", bus.spi_start, 0);

    // Simultaneous requests from a fresh pointer
    do_reset();
    bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req = 4'b1111;
    xfer("rr0", 2'd0, 8'h10, 8'h40);
    xfer("rr1", 2'd1, 8'h11, 8'h41);
    xfer("rr2", 2'd2, 8'h12, 8'h42);
    xfer("rr3", 2'd3, 8'h13, 8'h43);
    xfer("rr4", 2'd0, 8'h10, 8'h44);
    bus.req = 4'b0000;

    // Fairness: requester 1 held, requester 3 joins after 1's first grant
    do_reset();
    bus.req = 4'b0010;
    xfer("fr1", 2'd1, 8'h11, 8'h51);
    bus.req = 4'b1010;
    xfer("fr3", 2'd3, 8'h13, 8'h53);
    xfer("fr1b", 2'd1, 8'h11, 8'h55);
    bus.req = 4'b0000;

    // Spurious done in IDLE and ISSUE; dropped req and changed wdata mid-transfer
    tick();
    tick();
    tick();
    chk("sp_idle_busy", bus.busy, 0);
    bus.spi_done = 1'b1;
    tick();
    bus.spi_done = 1'b0;
    chk("sp_idle_busy2", bus.busy, 0);
    chk("sp_idle_ack", bus.ack, 0);
    chk("sp_idle_start", bus.spi_start, 0);
    bus.req = 4'b0001;
    tick();
    chk("sp_issue_start", bus.spi_start, 1);
    chk("sp_issue_grant", bus.grant_idx, 0);
    bus.spi_data_out = 8'hFF;
    bus.spi_done = 1'b1;
    bus.wdata[7:0] = 8'hEE;
    tick();
    bus.spi_done = 1'b0;
    chk("sp_wait_ack", bus.ack, 0);
    chk("sp_wait_busy", bus.busy, 1);
    chk("sp_wait_start", bus.spi_start, 0);
    chk("sp_wait_din", bus.spi_data_in, 8'h10);
    bus.req = 4'b0000;
    tick();
    chk("sp_wait2_ack", bus.ack, 0);
    chk("sp_wait2_busy", bus.busy, 1);
    bus.spi_data_out = 8'h5A;
    bus.spi_done = 1'b1;
    tick();
    bus.spi_done = 1'b0;
    chk("sp_ack", bus.ack, 4'b0001);
    chk("sp_rdata", bus.rdata, 8'h5A);
    tick();
    chk("sp_rdata_hold", bus.rdata, 8'h5A);
    chk("sp_gap_ack", bus.ack, 0);
    bus.wdata[7:0] = 8'h10;

    // Reset while waiting on requester 1
    tick();
    tick();
    bus.req = 4'b0010;
    tick();
    chk("rw_grant", bus.grant_idx, 1);
    tick();
    chk("rw_wait_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("rw_ack", bus.ack, 0);
    chk("rw_busy", bus.busy, 0);
    chk("rw_grant0", bus.grant_idx, 0);
    chk("rw_din", bus.spi_data_in, 0);
    chk("rw_rdata", bus.rdata, 0);
    chk("rw_start", bus.spi_start, 0);
    bus.spi_done = 1'b1;
    tick();
    chk("rw_ack_in_rst", bus.ack, 0);
    rst = 1'b0;
    bus.spi_done = 1'b0;
    chk("rw_ack_rel", bus.ack, 0);
    xfer("rw_after", 2'd1, 8'h11, 8'h99);
    bus.req = 4'b0000;

    // Gap timing on the 3-cycle-gap instance
    bus2.wdata = {8'h23, 8'h22, 8'h21, 8'h20};
    bus2.req = 4'b0011;
    n = 0;
    while (bus2.spi_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("g_start1", bus2.spi_start, 1);
    chk("g_grant1", bus2.grant_idx, 0);
    tick();
    bus2.spi_data_out = 8'h77;
    bus2.spi_done = 1'b1;
    tick();
    bus2.spi_done = 1'b0;
    chk("g_ack1", bus2.ack, 4'b0001);
    chk("g_rdata1", bus2.rdata, 8'h77);
    bus2.req = 4'b0010;
    n = 0;
    while (bus2.spi_start !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (n <= 3) chk("g_gap_busy", bus2.busy, 1);
      if (n == 4) chk("g_idle_busy", bus2.busy, 0);
    end
    chk("g_distance", n, 5);
    chk("g_grant2", bus2.grant_idx, 1);
    chk("g_din2", bus2.spi_data_in, 8'h21);
    tick();
    bus2.spi_data_out = 8'h88;
    bus2.spi_done = 1'b1;
    tick();
    bus2.spi_done = 1'b0;
    chk("g_ack2", bus2.ack, 4'b0010);
    chk("g_rdata2", bus2.rdata, 8'h88);
    bus2.req = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
